// File: rtl/cu_pkg.sv
// Shared types and encodings for the multicycle control unit.
// The main FSM, its output decoder and any other control-unit blocks import these.
package cu_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_e;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Raw per-state control word, before any memory-ready gating
    typedef struct packed {
        logic       irWrite;
        logic       nextPc;
        logic       adrSrc;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] resultSrc;
        logic       aluOp;
        logic       regW;
        logic       memW;
        logic       branch;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/fsm_out_dec_cu.sv
// Combinational state-to-control-word decoder for the main controller.
// Fetch strobes come out ungated; the caller qualifies them with memory ready.
module fsm_out_dec_cu
    import cu_pkg::*;
(
    input  logic [3:0] state_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = CTRL_IDLE;
        case (state_i)
            S_FETCH: begin
                ctrl_o.irWrite   = 1'b1;
                ctrl_o.nextPc    = 1'b1;
                ctrl_o.aluSrcA   = 1'b1;
                ctrl_o.aluSrcB   = SRCB_FOUR;
                ctrl_o.resultSrc = RES_ALU;
            end
            S_DECODE: begin
                ctrl_o.aluSrcA   = 1'b1;
                ctrl_o.aluSrcB   = SRCB_FOUR;
                ctrl_o.resultSrc = RES_ALU;
            end
            S_MEMADR: begin
                ctrl_o.aluSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                ctrl_o.adrSrc = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.resultSrc = RES_RDATA;
                ctrl_o.regW      = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl_o.adrSrc = 1'b1;
                ctrl_o.memW   = 1'b1;
            end
            S_EXECUTER: begin
                ctrl_o.aluOp = 1'b1;
            end
            S_EXECUTEI: begin
                ctrl_o.aluSrcB = SRCB_IMM;
                ctrl_o.aluOp   = 1'b1;
            end
            S_ALUWB: begin
                ctrl_o.regW = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.aluSrcB   = SRCB_IMM;
                ctrl_o.resultSrc = RES_ALU;
                ctrl_o.branch    = 1'b1;
            end
            default: begin
                ctrl_o = CTRL_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/main_fsm_cu.sv
// Multicycle main controller: state register, next-state logic and mem_ready gating.
// Raw reg_w/mem_w/branch strobes go to the conditional-logic stage for qualification.
module main_fsm_cu
    import cu_pkg::*;
#(
    parameter int unsigned USE_MEM_READY = 1
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       next_pc,
    output logic       adr_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       alu_op,
    output logic       reg_w,
    output logic       mem_w,
    output logic       branch,
    output logic [3:0] state
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrlRaw;
    logic   rdy;
    logic   unusedFunct;

    assign rdy         = (USE_MEM_READY != 0) ? mem_ready : 1'b1;
    assign unusedFunct = ^funct[4:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // op/funct only matter in DECODE and MEMADR; every other state ignores them
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_DP:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_MEM:  state_d = S_MEMADR;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                if (rdy) state_d = S_MEMWB;
            end
            S_MEMWRITE: begin
                if (rdy) state_d = S_FETCH;
            end
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_MEMWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    fsm_out_dec_cu u_outDec (
        .state_i (state_q),
        .ctrl_o  (ctrlRaw)
    );

    assign ir_write   = ctrlRaw.irWrite & rdy;
    assign next_pc    = ctrlRaw.nextPc & rdy;
    assign adr_src    = ctrlRaw.adrSrc;
    assign alu_src_a  = ctrlRaw.aluSrcA;
    assign alu_src_b  = ctrlRaw.aluSrcB;
    assign result_src = ctrlRaw.resultSrc;
    assign alu_op     = ctrlRaw.aluOp;
    assign reg_w      = ctrlRaw.regW;
    assign mem_w      = ctrlRaw.memW;
    assign branch     = ctrlRaw.branch;
    assign state      = state_q;

endmodule

// File: tb/tb_main_fsm_cu.sv
// Directed-vector bench for main_fsm_cu: per-cycle table of inputs and expected
// state/outputs, plus hand sequences for reset during a write stall and USE_MEM_READY=0.
module tb_main_fsm_cu;

    // Expected output word: {ir_write,next_pc,adr_src,alu_src_a,alu_src_b,result_src,alu_op,reg_w,mem_w,branch}
    localparam logic [11:0] O_FETCH  = 12'b1101_1010_0000;
    localparam logic [11:0] O_FSTALL = 12'b0001_1010_0000;
    localparam logic [11:0] O_DECODE = 12'b0001_1010_0000;
    localparam logic [11:0] O_MEMADR = 12'b0000_0100_0000;
    localparam logic [11:0] O_MEMRD  = 12'b0010_0000_0000;
    localparam logic [11:0] O_MEMWB  = 12'b0000_0001_0100;
    localparam logic [11:0] O_MEMWR  = 12'b0010_0000_0010;
    localparam logic [11:0] O_EXECR  = 12'b0000_0000_1000;
    localparam logic [11:0] O_EXECI  = 12'b0000_0100_1000;
    localparam logic [11:0] O_ALUWB  = 12'b0000_0000_0100;
    localparam logic [11:0] O_BRANCH = 12'b0000_0110_0001;

    localparam logic [3:0] T_FETCH = 4'd0, T_DECODE = 4'd1, T_MEMADR = 4'd2, T_MEMREAD = 4'd3,
                           T_MEMWB = 4'd4, T_MEMWRITE = 4'd5, T_EXECR = 4'd6, T_EXECI = 4'd7,
                           T_ALUWB = 4'd8, T_BRANCH = 4'd9;

    typedef struct packed {
        logic        rst;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic        rdy;
        logic [3:0]  expState;
        logic [11:0] expOut;
    } vec_t;

    logic clk = 1'b0;
    logic reset, memReady;
    logic [1:0] op;
    logic [5:0] funct;

    logic irWrite, nextPc, adrSrc, aluSrcA, aluOp, regW, memW, branchO;
    logic [1:0] aluSrcB, resultSrc;
    logic [3:0] state;

    logic irWrite0, nextPc0, adrSrc0, aluSrcA0, aluOp0, regW0, memW0, branch0;
    logic [1:0] aluSrcB0, resultSrc0;
    logic [3:0] state0;

    logic [11:0] gotOut;
    int total = 0;
    int bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    assign gotOut = {irWrite, nextPc, adrSrc, aluSrcA, aluSrcB, resultSrc, aluOp, regW, memW, branchO};

    main_fsm_cu #(.USE_MEM_READY(1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(memReady),
        .ir_write(irWrite), .next_pc(nextPc), .adr_src(adrSrc), .alu_src_a(aluSrcA),
        .alu_src_b(aluSrcB), .result_src(resultSrc), .alu_op(aluOp),
        .reg_w(regW), .mem_w(memW), .branch(branchO), .state(state)
    );

    main_fsm_cu #(.USE_MEM_READY(0)) dutNoRdy (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(memReady),
        .ir_write(irWrite0), .next_pc(nextPc0), .adr_src(adrSrc0), .alu_src_a(aluSrcA0),
        .alu_src_b(aluSrcB0), .result_src(resultSrc0), .alu_op(aluOp0),
        .reg_w(regW0), .mem_w(memW0), .branch(branch0), .state(state0)
    );

    function automatic vec_t mkVec(input logic r, input logic [1:0] o, input logic [5:0] f,
                                   input logic m, input logic [3:0] s, input logic [11:0] e);
        vec_t v;
        v.rst = r; v.op = o; v.funct = f; v.rdy = m; v.expState = s; v.expOut = e;
        return v;
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        reset    = v.rst;
        op       = v.op;
        funct    = v.funct;
        memReady = v.rdy;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [11:0] got, input logic [11:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        bit found;

        // Data-processing register form
        vecs.push_back(mkVec(0, 2'b00, 6'b000000, 1, T_FETCH,    O_FETCH));
        vecs.push_back(mkVec(0, 2'b00, 6'b000000, 1, T_DECODE,   O_DECODE));
        vecs.push_back(mkVec(0, 2'b00, 6'b000000, 1, T_EXECR,    O_EXECR));
        vecs.push_back(mkVec(0, 2'b00, 6'b000000, 1, T_ALUWB,    O_ALUWB));
        // LDR with two-cycle stalls in FETCH and MEMREAD
        vecs.push_back(mkVec(0, 2'b01, 6'b011001, 0, T_FETCH,    O_FSTALL));
        vecs.push_back(mkVec(0, 2'b01, 6'b011001, 0, T_FETCH,    O_FSTALL));
        vecs.push_back(mkVec(0, 2'b01, 6'b011001, 1, T_FETCH,    O_FETCH));
        vecs.push_back(mkVec(0, 2'b01, 6'b011001, 1, T_DECODE,   O_DECODE));
        vecs.push_back(mkVec(0, 2'b01, 6'b011001, 1, T_MEMADR,   O_MEMADR));
        vecs.push_back(mkVec(0, 2'b01, 6'b011001, 0, T_MEMREAD,  O_MEMRD));
        vecs.push_back(mkVec(0, 2'b01, 6'b011001, 0, T_MEMREAD,  O_MEMRD));
        vecs.push_back(mkVec(0, 2'b01, 6'b011001, 1, T_MEMREAD,  O_MEMRD));
        vecs.push_back(mkVec(0, 2'b01, 6'b011001, 1, T_MEMWB,    O_MEMWB));
        // STR with one stall cycle in MEMWRITE
        vecs.push_back(mkVec(0, 2'b01, 6'b011000, 1, T_FETCH,    O_FETCH));
        vecs.push_back(mkVec(0, 2'b01, 6'b011000, 1, T_DECODE,   O_DECODE));
        vecs.push_back(mkVec(0, 2'b01, 6'b011000, 1, T_MEMADR,   O_MEMADR));
        vecs.push_back(mkVec(0, 2'b01, 6'b011000, 0, T_MEMWRITE, O_MEMWR));
        vecs.push_back(mkVec(0, 2'b01, 6'b011000, 1, T_MEMWRITE, O_MEMWR));
        // Branch, then unsupported op
        vecs.push_back(mkVec(0, 2'b10, 6'b000000, 1, T_FETCH,    O_FETCH));
        vecs.push_back(mkVec(0, 2'b10, 6'b000000, 1, T_DECODE,   O_DECODE));
        vecs.push_back(mkVec(0, 2'b10, 6'b000000, 1, T_BRANCH,   O_BRANCH));
        vecs.push_back(mkVec(0, 2'b11, 6'b000000, 1, T_FETCH,    O_FETCH));
        vecs.push_back(mkVec(0, 2'b11, 6'b000000, 1, T_DECODE,   O_DECODE));
        // Immediate data-processing
        vecs.push_back(mkVec(0, 2'b00, 6'b100000, 1, T_FETCH,    O_FETCH));
        vecs.push_back(mkVec(0, 2'b00, 6'b100000, 1, T_DECODE,   O_DECODE));
        vecs.push_back(mkVec(0, 2'b00, 6'b100000, 1, T_EXECI,    O_EXECI));
        vecs.push_back(mkVec(0, 2'b00, 6'b100000, 1, T_ALUWB,    O_ALUWB));
        // op/funct changed after DECODE must not redirect the path
        vecs.push_back(mkVec(0, 2'b00, 6'b000000, 1, T_FETCH,    O_FETCH));
        vecs.push_back(mkVec(0, 2'b00, 6'b000000, 1, T_DECODE,   O_DECODE));
        vecs.push_back(mkVec(0, 2'b11, 6'b100001, 1, T_EXECR,    O_EXECR));
        vecs.push_back(mkVec(0, 2'b01, 6'b111111, 1, T_ALUWB,    O_ALUWB));
        // Reset held two cycles starting from EXECUTER
        vecs.push_back(mkVec(0, 2'b00, 6'b000000, 1, T_FETCH,    O_FETCH));
        vecs.push_back(mkVec(0, 2'b00, 6'b000000, 1, T_DECODE,   O_DECODE));
        vecs.push_back(mkVec(1, 2'b00, 6'b000000, 1, T_EXECR,    O_EXECR));
        vecs.push_back(mkVec(1, 2'b10, 6'b000000, 1, T_FETCH,    O_FETCH));
        vecs.push_back(mkVec(0, 2'b10, 6'b000000, 0, T_FETCH,    O_FSTALL));

        reset = 1'b1; memReady = 1'b1; op = 2'b00; funct = 6'b000000;
        stepCycle();
        stepCycle();

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("row%0d_state", i), {8'b0, state}, {8'b0, vecs[i].expState});
            checkOutput($sformatf("row%0d_outs", i), gotOut, vecs[i].expOut);
            stepCycle();
        end

        // Reset asserted while a store is stalled in MEMWRITE
        reset = 1'b0; op = 2'b01; funct = 6'b011000; memReady = 1'b1;
        stepCycle();
        memReady = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (state == T_MEMWRITE) found = 1'b1;
            else stepCycle();
        end
        checkOutput("reach_memwrite", {11'b0, found}, 12'd1);
        checkOutput("memw_in_stall", {11'b0, memW}, 12'd1);
        reset = 1'b1;
        stepCycle();
        checkOutput("rst_mid_str_state", {8'b0, state}, {8'b0, T_FETCH});
        checkOutput("rst_mid_str_memw", {11'b0, memW}, 12'd0);
        checkOutput("rst_fetch_irw_gated", {11'b0, irWrite}, 12'd0);
        checkOutput("nordy_fetch_irw", {10'b0, irWrite0, nextPc0}, 12'd3);
        reset = 1'b0;
        stepCycle();
        checkOutput("fetch_stall_hold", {8'b0, state}, {8'b0, T_FETCH});
        checkOutput("nordy_fetch_advance", {8'b0, state0}, {8'b0, T_DECODE});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/main_fsm_cu.md
Name: main_fsm_cu

Overview:
- Multicycle main controller FSM of the control unit.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the datapath mux selects and the raw reg_w / mem_w / branch strobes.
- Those strobes feed the conditional-logic stage, which gates them with the condition check; this block makes no condition decisions.

Parameters:
- USE_MEM_READY, 1: 1 = FETCH / MEMREAD / MEMWRITE wait for mem_ready; 0 = mem_ready ignored (treated as 1).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high; forces state FETCH
- op  input  2  instruction op field (Instr[27:26])
- funct  input  6  instruction funct field (Instr[25:20]); bit5 = I (immediate), bit0 = L/S
- mem_ready  input  1  memory handshake; access completes on the cycle it is high
- ir_write  output  1  instruction register load enable
- next_pc  output  1  PC update request (fetch increment)
- adr_src  output  1  0 = address from PC, 1 = address from ALU result
- alu_src_a  output  1  0 = register A, 1 = PC
- alu_src_b  output  2  00 = register B, 01 = extended immediate, 10 = constant 4
- result_src  output  2  00 = ALU out register, 01 = read data, 10 = ALU result direct
- alu_op  output  1  1 = ALU decoder uses funct; 0 = forced ADD
- reg_w  output  1  raw register-write strobe to conditional logic
- mem_w  output  1  raw memory-write strobe to conditional logic
- branch  output  1  raw branch strobe to conditional logic
- state  output  4  current state encoding (debug/verification)

Behaviour:
- State register updates on rising clk. reset=1 at an edge: next state FETCH regardless of current state or inputs, including mid-MEMWRITE with mem_w high.
- Outputs are a function of the current state, zero latency. mem_ready gating is the only Mealy term. Any output not listed for a state is 0.
- After reset all outputs equal the FETCH row below; reg_w = mem_w = branch = 0.
- Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9. Unused codes 10-15 go to FETCH next cycle with all outputs 0.
- Output rows per state:
  - FETCH: alu_src_a=1, alu_src_b=10, result_src=10; ir_write=next_pc=rdy (rdy = mem_ready, or 1 if USE_MEM_READY=0).
  - DECODE: alu_src_a=1, alu_src_b=10, result_src=10.
  - MEMADR: alu_src_b=01.
  - MEMREAD: adr_src=1.
  - MEMWB: result_src=01, reg_w=1.
  - MEMWRITE: adr_src=1, mem_w=1 (held for the whole stall).
  - EXECUTER: alu_op=1.
  - EXECUTEI: alu_src_b=01, alu_op=1.
  - ALUWB: reg_w=1.
  - BRANCH: alu_src_b=01, result_src=10, branch=1.
- Transitions:
  - FETCH -> DECODE if rdy, else stay.
  - DECODE:
    - op=00 and funct[5]=0 -> EXECUTER
    - op=00 and funct[5]=1 -> EXECUTEI
    - op=01 -> MEMADR
    - op=10 -> BRANCH
    - op=11 -> FETCH (unsupported op, NOP; no strobes)
  - MEMADR -> MEMREAD if funct[0]=1, else MEMWRITE.
  - MEMREAD -> MEMWB if rdy, else stay.
  - MEMWRITE -> FETCH if rdy, else stay.
  - EXECUTER, EXECUTEI -> ALUWB.
  - ALUWB, MEMWB, BRANCH -> FETCH.
- Cycle counts with rdy=1 throughout:
  - data-processing: 4 cycles
  - LDR: 5 cycles
  - STR: 4 cycles
  - branch: 3 cycles
  - op=11: 2 cycles
- op/funct are sampled only in DECODE and MEMADR. Changes in other states have no effect.
- reg_w, mem_w and branch are mutually exclusive in every state.

Decomposition:
- Shared package cu_pkg:
  - state enum (4-bit, encodings above)
  - alu_src_b constants SRCB_REG / SRCB_IMM / SRCB_FOUR
  - result_src constants RES_ALUOUT / RES_RDATA / RES_ALU
  - op constants OP_DP / OP_MEM / OP_BR
- One sub-module fsm_out_dec_cu: purely combinational state-to-output decoder, without the mem_ready gating.
- main_fsm_cu holds the state register, next-state logic and rdy gating.

Test Plan:
- Reset: hold reset 2 cycles from an arbitrary state -> state=0, ir_write=1 (mem_ready=1), alu_src_b=10, result_src=10, reg_w=mem_w=branch=0.
- ADD register (op=00, funct=000000, mem_ready=1) -> states 0,1,6,8,0; alu_op=1 in state 6; reg_w=1 only in state 8.
- LDR with wait (op=01, funct=011001; mem_ready low for 2 cycles in FETCH and MEMREAD) -> FETCH and MEMREAD each held 3 cycles; ir_write=0 while stalled, 1 on the ready cycle; then 4; reg_w=1, result_src=01 in state 4.
- STR (op=01, funct=011000), mem_ready low 1 cycle in MEMWRITE -> states 0,1,2,5,5,0; mem_w=1 and adr_src=1 both cycles in state 5.
- Branch and unsupported op: op=10 -> 0,1,9,0 with branch=1, alu_src_b=01 in 9; op=11 -> 0,1,0 with no strobes.
- Reset mid-op: assert reset during MEMWRITE with mem_ready=0 -> next cycle state=0, mem_w=0; op changed during state 6 does not alter the path to state 8.
